serial_to_parallel_bc: RTL

//  Receive-side front end of the serial link. Deserializes the 1-bit stream at clk_32f into bytes.

---
 rtl/serial_to_parallel_bc_pkg.sv | 18 +
 rtl/serial_to_parallel_bc_shift_reg8_ser.sv | 21 ++
 rtl/serial_to_parallel_bc.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_bc_pkg.sv
// Shared link symbols and receive/transmit FSM state encodings.
// Reused by the serial_to_parallel_bc receiver and the parallel-to-serial transmitter.
package serial_to_parallel_bc_pkg;

  localparam logic [7:0] COMMA           = 8'hBC;
  localparam int         COMMA_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  function automatic logic is_comma(input logic [7:0] b);
    return b == COMMA;
  endfunction

endpackage

// File: rtl/serial_to_parallel_bc_shift_reg8_ser.sv
// 8-bit MSB-first serial shift register; cand_o is the byte completed by data_i this edge.
// Ports: clk_i, rst_ni (sync, active-low), data_i (serial bit), cand_o (candidate byte).
module shift_reg8_ser (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  output logic [7:0] cand_o
);

  logic [7:0] sr_q;
  logic [7:0] sr_d;

  assign sr_d   = {sr_q[6:0], data_i};
  assign cand_o = sr_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sr_q <= 8'h00;
    else         sr_q <= sr_d;
  end

endmodule

// File: rtl/serial_to_parallel_bc.sv
// Serial link receive front end: deserializes clk_32f bit stream into bytes, locks on commas.
// Ports: clk_32f, reset_L, data_in -> data_out[7:0], valid_out, byte_strobe, active.
module serial_to_parallel_bc
  import serial_to_parallel_bc_pkg::*;
#(
  parameter int COMMA_COUNT = COMMA_COUNT_DEF
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] CC = 4'(COMMA_COUNT);

  logic [7:0] cand;
  logic       cand_comma;
  logic       boundary;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  shift_reg8_ser u_sr (
    .clk_i  (clk_32f),
    .rst_ni (reset_L),
    .data_i (data_in),
    .cand_o (cand)
  );

  assign cand_comma = is_comma(cand);
  assign boundary   = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;
    unique case (state_q)
      ST_SEARCH: begin
        bit_cnt_d = 3'd0;
        if (cand_comma) begin
          bc_cnt_d = 4'd1;
          if (CC == 4'd1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          data_d   = cand;
          valid_d  = 1'b0;
          if (cand_comma) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == CC) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // Lost alignment: resume bit-wise search on the next edge.
            bc_cnt_d = 4'd0;
            state_d  = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          data_d   = cand;
          valid_d  = !cand_comma;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q   <= ST_SEARCH;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule
